// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master side) and the
// system-ID slave. One-bit word address: 0 = ID word, 1 = timestamp word.
interface soc_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdatavalid,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdatavalid,
        output avm_readdata
    );
endinterface

// File: rtl/soc_system_sysid_checker.sv
// System-ID checker: reads the ID word (address 0) and the timestamp word
// (address 1) from the sysid slave, compares both against build-time values
// and reports pass / mismatch / timeout. One sequence runs after reset
// (AUTO_START) and one per start pulse taken while idle.
module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h557474E0,
    // Cycles allowed per read transaction before it is abandoned (1..65535).
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    soc_system_sysid_checker_if.master         avm,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               id_mismatch,
    output logic                               ts_mismatch,
    output logic                               timeout,
    output logic [31:0]                        id_value,
    output logic [31:0]                        ts_value
);

    // Counter is just wide enough to hold TIMEOUT_CYCLES itself.
    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID_REQ,
        S_ID_WAIT,
        S_TS_REQ,
        S_TS_WAIT,
        S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             auto_pend_q, auto_pend_d;

    logic             read_q, read_d;
    logic             addr_q, addr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             id_mismatch_q, id_mismatch_d;
    logic             ts_mismatch_q, ts_mismatch_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      id_value_q, id_value_d;
    logic [31:0]      ts_value_q, ts_value_d;

    logic             accept;
    logic             expired;
    logic             abort;
    logic [CNT_W-1:0] cnt_step;

    // Sequence control: next state, transaction timer, word capture and the
    // status flags that are settled on entry to FINISH.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        auto_pend_d   = auto_pend_q;
        pass_d        = pass_q;
        id_mismatch_d = id_mismatch_q;
        ts_mismatch_d = ts_mismatch_q;
        timeout_d     = timeout_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        abort         = 1'b0;

        // A read is accepted on the first cycle the strobe is up and not stalled.
        accept   = read_q && !avm.avm_waitrequest;
        expired  = (cnt_q == CNT_LIMIT);
        // Saturate so a read accepted right at the limit cannot wrap the timer.
        cnt_step = expired ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start || auto_pend_q) begin
                    state_d       = S_ID_REQ;
                    auto_pend_d   = 1'b0;
                    cnt_d         = '0;
                    pass_d        = 1'b0;
                    id_mismatch_d = 1'b0;
                    ts_mismatch_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end

            S_ID_REQ: begin
                cnt_d = cnt_step;
                if (accept && avm.avm_readdatavalid) begin
                    // Zero-latency slave: data arrives with the accept.
                    id_value_d = avm.avm_readdata;
                    state_d    = S_TS_REQ;
                    cnt_d      = '0;
                end else if (accept) begin
                    state_d = S_ID_WAIT;
                end else if (expired) begin
                    state_d = S_FINISH;
                    abort   = 1'b1;
                end
            end

            S_ID_WAIT: begin
                cnt_d = cnt_step;
                if (avm.avm_readdatavalid) begin
                    id_value_d = avm.avm_readdata;
                    state_d    = S_TS_REQ;
                    cnt_d      = '0;
                end else if (expired) begin
                    state_d = S_FINISH;
                    abort   = 1'b1;
                end
            end

            S_TS_REQ: begin
                cnt_d = cnt_step;
                if (accept && avm.avm_readdatavalid) begin
                    ts_value_d = avm.avm_readdata;
                    state_d    = S_FINISH;
                end else if (accept) begin
                    state_d = S_TS_WAIT;
                end else if (expired) begin
                    state_d = S_FINISH;
                    abort   = 1'b1;
                end
            end

            S_TS_WAIT: begin
                cnt_d = cnt_step;
                if (avm.avm_readdatavalid) begin
                    ts_value_d = avm.avm_readdata;
                    state_d    = S_FINISH;
                end else if (expired) begin
                    state_d = S_FINISH;
                    abort   = 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // FINISH always returns to IDLE, so this only fires on entry to FINISH.
        // Flags use the freshly captured words so they line up with done.
        if (state_d == S_FINISH) begin
            if (abort) begin
                timeout_d     = 1'b1;
                id_mismatch_d = 1'b0;
                ts_mismatch_d = 1'b0;
                pass_d        = 1'b0;
            end else begin
                id_mismatch_d = (id_value_d != EXPECTED_ID);
                ts_mismatch_d = (ts_value_d != EXPECTED_TS);
                pass_d        = !id_mismatch_d && !ts_mismatch_d;
            end
        end

        // Bus and handshake outputs are registered images of the next state.
        read_d = (state_d == S_ID_REQ) || (state_d == S_TS_REQ);
        addr_d = (state_d == S_TS_REQ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State and registered outputs; reset clears everything and aborts any
    // sequence in flight without a done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            auto_pend_q   <= AUTO_START;
            read_q        <= 1'b0;
            addr_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_mismatch_q <= 1'b0;
            ts_mismatch_q <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values,
            // independent of statement order.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            auto_pend_q   <= auto_pend_d;
            read_q        <= read_d;
            addr_q        <= addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            id_mismatch_q <= id_mismatch_d;
            ts_mismatch_q <= ts_mismatch_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm.avm_read    = read_q;
    assign avm.avm_address = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign id_mismatch     = id_mismatch_q;
    assign ts_mismatch     = ts_mismatch_q;
    assign timeout         = timeout_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;

endmodule

// File: doc/soc_system_sysid_checker.md
Name: soc_system_sysid_checker

Overview:
- Avalon-MM read master that sequences the two reads of the system-ID slave: ID word at address 0, then timestamp word at address 1.
- Captures both words, compares them against build-time expected values, and reports pass, mismatch or timeout to HPS-visible status logic and the LEDs.
- Sits beside the sysid slave in soc_system and runs once after reset (optional) or on each start pulse.

Parameters:
- EXPECTED_ID, 32'hACD51302, ID value the system must report.
- EXPECTED_TS, 32'h557474E0, timestamp value the system must report.
- TIMEOUT_CYCLES, 255, maximum cycles per read transaction before abort; legal range 1..65535.
- AUTO_START, 1, 1 = start one check sequence automatically after reset release.

Ports:
- clock, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to run a check sequence.
- avm_address, output, 1, read word select: 0 = ID, 1 = timestamp.
- avm_read, output, 1, Avalon read strobe.
- avm_waitrequest, input, 1, slave stall.
- avm_readdatavalid, input, 1, read data qualifier.
- avm_readdata, input, 32, read data.
- busy, output, 1, sequence in progress.
- done, output, 1, one-cycle pulse when a sequence ends.
- pass, output, 1, last sequence matched both words.
- id_mismatch, output, 1, last captured ID differed from EXPECTED_ID.
- ts_mismatch, output, 1, last captured timestamp differed from EXPECTED_TS.
- timeout, output, 1, last sequence was aborted by timeout.
- id_value, output, 32, last captured ID word.
- ts_value, output, 32, last captured timestamp word.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Every output clears to 0, including id_value and ts_value. Status flags clear as well.
  - FSM goes to IDLE; timeout counter clears to 0.
  - Reset asserted mid-sequence aborts the sequence immediately. No done pulse is produced.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE:
  - Moves to ID_REQ on start=1, or on the first cycle after reset release when AUTO_START=1.
  - On entry to ID_REQ, clear pass, id_mismatch, ts_mismatch and timeout.
- ID_REQ and TS_REQ:
  - Drive avm_read=1 with avm_address=0 (ID_REQ) or 1 (TS_REQ).
  - Hold avm_read and avm_address stable while avm_waitrequest=1.
  - Accept on the first cycle with avm_read=1 and avm_waitrequest=0, then move to the matching WAIT state. avm_read deasserts the following cycle.
- ID_WAIT and TS_WAIT:
  - Capture avm_readdata into id_value or ts_value on the cycle avm_readdatavalid=1.
  - If avm_readdatavalid=1 arrives in the same cycle as the accept, capture then and skip the WAIT state. A zero-latency slave must work.
  - ID_WAIT then moves to TS_REQ; TS_WAIT moves to FINISH.
  - avm_readdatavalid outside a WAIT state (or the same-cycle accept case) is ignored.
- Comparison (evaluated in FINISH):
  - id_mismatch = (id_value != EXPECTED_ID).
  - ts_mismatch = (ts_value != EXPECTED_TS).
  - pass = neither mismatch and no timeout.
- Timeout:
  - Counter width is ceil(log2(TIMEOUT_CYCLES+1)).
  - Counter clears on entry to each REQ state and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: deassert avm_read, set timeout=1, go to FINISH.
  - After a timeout, skip both comparisons (id_mismatch = ts_mismatch = 0).
  - Captured values not re-read keep their previous contents.
- FINISH: one cycle. done=1 and flags updated in the same cycle. Then return to IDLE.
- busy=1 in every state except IDLE.
- Status outputs hold until the next sequence starts.
- start while busy=1 is ignored; there is no queuing.
- Exactly one outstanding read at any time.
- Nominal latency with a zero-wait, 1-cycle readdatavalid slave: 5 cycles from start to done.

Test Plan:
- Slave returns 0xACD51302 at address 0 and 0x557474E0 at address 1, no stalls → done after 5 cycles; pass=1; both mismatch flags and timeout are 0.
- Slave returns 0xACD51303 for the ID → pass=0, id_mismatch=1, ts_mismatch=0, id_value=0xACD51303.
- avm_waitrequest held high for 10 cycles on the timestamp read → avm_read and avm_address=1 stay stable throughout; pass=1; done arrives 10 cycles later than nominal.
- TIMEOUT_CYCLES=8 and the slave never asserts avm_readdatavalid on the ID read → avm_read drops; timeout=1, pass=0; done pulses; no timestamp read is issued.
- reset_n asserted while in TS_WAIT → all outputs 0 on the asynchronous edge; with AUTO_START=1 a fresh sequence starts after release and passes.
- start pulsed while busy=1, then again after done → the first pulse is ignored (exactly 2 reads seen); the second runs a full sequence.
